// File: rtl/rr_mux_arbiter_pkg.sv
// Shared encodings for the two-source round-robin mux arbiter.
// No logic of its own; constants only.
// Source and state encodings are fixed so debug views stay comparable.
package rr_mux_arbiter_pkg;

  // Source encoding, matching the downstream mux select (0 picks a, 1 picks b)
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Output register occupancy
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: q reflects an inc one cycle later.
// No backpressure; inc is sampled every cycle, excess events at saturation are ignored.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up on inc, hold once the maximum is reached instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (inc && (q != CNT_MAX)) begin
      q <= q + CNT_ONE;
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-source round-robin arbiter driving a 2:1 mux select into a one-entry output register.
// Latency: word accepted in cycle N is presented on out_* in cycle N+1.
// Backpressure: readys drop while the register is full and out_ready is low; drain+refill in one cycle.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic state_q;   // output register occupancy
  logic last_q;    // source granted most recently; the other one wins a tie
  logic sel_q;     // select held while no new grant is made

  logic slot_free;
  logic grant;
  logic take;
  logic accept;
  logic inc_a;
  logic inc_b;

  // Arbitration and handshake: grant only when the register can take a word
  always_comb begin
    slot_free = (state_q == ST_EMPTY) | out_ready;
    if (a_valid & b_valid) begin
      grant = ~last_q;
    end else if (b_valid) begin
      grant = SRC_B;
    end else begin
      grant = SRC_A;
    end
    // rst_n gates take so no ready leaks out while reset is held
    take    = rst_n & slot_free & (a_valid | b_valid);
    sel     = take ? grant : sel_q;
    a_ready = take & (grant == SRC_A) & a_valid;
    b_ready = take & (grant == SRC_B) & b_valid;
    inc_a   = a_valid & a_ready;
    inc_b   = b_valid & b_ready;
    accept  = inc_a | inc_b;
  end

  assign out_valid = (state_q == ST_FULL);

  // Occupancy, priority pointer and output register; a new word may replace one being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      last_q   <= SRC_B;
      sel_q    <= SRC_A;
      out_data <= '0;
      out_src  <= SRC_A;
    end else if (accept) begin
      state_q  <= ST_FULL;
      out_data <= sel ? b_data : a_data;
      out_src  <= sel;
      last_q   <= sel;
      sel_q    <= sel;
    end else if (out_ready) begin
      state_q  <= ST_EMPTY;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_a),
    .q     (cnt_a)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_b),
    .q     (cnt_b)
  );

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus a randomized phase.
// A behavioural model predicts each cycle's grant and queues the expected words;
// a separate monitor compares whatever the DUT presents against that queue.
module tb_rr_mux_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  typedef struct packed {
    logic             src;
    logic [WIDTH-1:0] dat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;
  logic             out_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t sb_q[$];

  // model state
  logic m_full;
  logic m_last;
  logic m_sel;
  int   m_cnt_a;
  int   m_cnt_b;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Reference model: round-robin on ties, single valid source wins outright,
  // nothing is taken while the register is full and not being drained.
  always @(negedge clk) begin
    logic slot;
    logic acc;
    logic win;
    if (!rst_n) begin
      m_full  = 1'b0;
      m_last  = 1'b1;
      m_sel   = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
    end else begin
      slot = !m_full || out_ready;
      acc  = slot && (a_valid || b_valid);
      win  = (a_valid && b_valid) ? !m_last : b_valid;
      chk("a_ready", 32'(a_ready), 32'(acc && !win));
      chk("b_ready", 32'(b_ready), 32'(acc && win));
      chk("sel", 32'(sel), 32'(acc ? win : m_sel));
      chk("out_valid", 32'(out_valid), 32'(m_full));
      chk("cnt_a", 32'(cnt_a), 32'(sat(m_cnt_a)));
      chk("cnt_b", 32'(cnt_b), 32'(sat(m_cnt_b)));
      if (acc) begin
        sb_q.push_back('{src: win, dat: (win ? b_data : a_data)});
        m_last = win;
        m_sel  = win;
        if (win) m_cnt_b++;
        else     m_cnt_a++;
      end
      m_full = acc || (m_full && !out_ready);
    end
  end

  // Monitor: compare the presented word with the oldest expected one, pop on transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL out_unexpected: got data %0h src %0d, expected no word", out_data, out_src);
      end else begin
        chk("out_data", 32'(out_data), 32'(sb_q[0].dat));
        chk("out_src", 32'(out_src), 32'(sb_q[0].src));
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic drive(input logic av, input logic [WIDTH-1:0] ad,
                       input logic bv, input logic [WIDTH-1:0] bd, input logic ordy);
    a_valid   = av;
    a_data    = ad;
    b_valid   = bv;
    b_data    = bd;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic a_acc;
    logic b_acc;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // reset then idle
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_sel", 32'(sel), 32'd0);
    chk("idle_cnt_a", 32'(cnt_a), 32'd0);
    chk("idle_cnt_b", 32'(cnt_b), 32'd0);
    chk("idle_readys", 32'({a_ready, b_ready}), 32'd0);

    // single A word
    drive(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk("single_a_ready", 32'(a_ready), 32'd1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("single_out_valid", 32'(out_valid), 32'd1);
    chk("single_out_data", 32'(out_data), 32'h3C);
    chk("single_out_src", 32'(out_src), 32'd0);
    chk("single_cnt_a", 32'(cnt_a), 32'd1);
    tick();

    // fresh priority pointer for the tie test
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // tie fairness: A,B,A,B
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tie_data", 32'(out_data), (i % 2 == 1) ? 32'h22 : 32'h11);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk("tie_cnt_a", 32'(cnt_a), 32'd2);
    chk("tie_cnt_b", 32'(cnt_b), 32'd2);

    // back-pressure: hold 0x22 for 5 cycles with both sources waiting
    drive(1'b0, 8'h00, 1'b1, 8'h22, 1'b1);
    tick();
    drive(1'b1, 8'h33, 1'b1, 8'h44, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", 32'(out_data), 32'h22);
      chk("stall_sel", 32'(sel), 32'd1);
      chk("stall_readys", 32'({a_ready, b_ready}), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_a_ready", 32'(a_ready), 32'd1);
    chk("unstall_b_ready", 32'(b_ready), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("unstall_data", 32'(out_data), 32'h33);
    repeat (2) tick();

    // saturation: 20 A transfers on a 4-bit counter
    drive(1'b1, 8'h05, 1'b0, 8'h00, 1'b1);
    repeat (20) tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk("sat_cnt_a", 32'(cnt_a), 32'd15);
    tick();

    // randomized traffic; sources hold their word until accepted
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a_acc = a_valid && a_ready;
      b_acc = b_valid && b_ready;
      @(posedge clk);
      #1;
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data  = WIDTH'($urandom);
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data  = WIDTH'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // mid-stall asynchronous reset
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    repeat (2) tick();
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    tick();
    drive(1'b1, 8'h78, 1'b1, 8'h79, 1'b0);
    repeat (2) tick();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_out_data", 32'(out_data), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    chk("rst_readys", 32'({a_ready, b_ready}), 32'd0);
    repeat (2) tick();
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_b_ready", 32'(b_ready), 32'd0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    chk("post_rst_data", 32'(out_data), 32'h78);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
